mio_bus_arbiter: RTL and testbench

//  Two-port arbiter/sequencer sharing one memory/IO bus between the multi-cycle CPU (port C) and a DMA/display requester (port D).

---
 rtl/mio_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mio_bus_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares one memory/IO bus between the CPU (port C) and a
// DMA/display requester (port D). The winning request is latched, the bus is
// driven for MEM_LAT cycles, read data is captured, and the winner receives a
// one-cycle ready pulse.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate on simultaneous
// requests); when undefined, C has fixed priority over D.
module mio_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [1:0]       GNT_C    = 2'b01;
  localparam logic [1:0]       GNT_D    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_last_d;      // 1 = last grant went to D
  logic [1:0]          r_grant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dma_rdata;
  logic                r_cpu_ready;
  logic                r_dma_ready;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_last_d_nxt;
  logic [1:0]          w_grant_nxt;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic                w_mem_en_nxt;
  logic                w_mem_we_nxt;
  logic [DATA_W-1:0]   w_cpu_rdata_nxt;
  logic [DATA_W-1:0]   w_dma_rdata_nxt;
  logic                w_cpu_ready_nxt;
  logic                w_dma_ready_nxt;
  logic                w_pick_c;
  logic                w_pick_d;

  // Arbitration: choose the IDLE-state winner
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    w_pick_c = cpu_req & (~dma_req | r_last_d);
`else
    w_pick_c = cpu_req;
`endif
    w_pick_d = dma_req & ~w_pick_c;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_d_nxt    = r_last_d;
    w_grant_nxt     = r_grant;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dma_rdata_nxt = r_dma_rdata;
    w_cpu_ready_nxt = 1'b0;
    w_dma_ready_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_grant_nxt = 2'b00;
        if (w_pick_c || w_pick_d) begin
          w_state_nxt  = ST_ACCESS;
          w_cnt_nxt    = '0;
          w_grant_nxt  = w_pick_c ? GNT_C : GNT_D;
          w_last_d_nxt = w_pick_d;
          w_we_nxt     = w_pick_c ? cpu_we    : dma_we;
          w_addr_nxt   = w_pick_c ? cpu_addr  : dma_addr;
          w_wdata_nxt  = w_pick_c ? cpu_wdata : dma_wdata;
          w_mem_en_nxt = 1'b1;
          w_mem_we_nxt = w_pick_c ? cpu_we    : dma_we;
        end
      end
      ST_ACCESS: begin
        if (r_cnt != CNT_LAST) begin
          w_cnt_nxt    = r_cnt + CNT_W'(1);
          w_mem_en_nxt = 1'b1;
          w_mem_we_nxt = r_we;
        end else begin
          w_state_nxt = ST_DONE;
          if (r_grant == GNT_C) begin
            w_cpu_ready_nxt = 1'b1;
            if (!r_we) w_cpu_rdata_nxt = mem_rdata;
          end else begin
            w_dma_ready_nxt = 1'b1;
            if (!r_we) w_dma_rdata_nxt = mem_rdata;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  // State and output registers; async reset aborts any transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_last_d    <= 1'b1;
      r_grant     <= 2'b00;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_d    <= w_last_d_nxt;
      r_grant     <= w_grant_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dma_rdata <= w_dma_rdata_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_dma_ready <= w_dma_ready_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign dma_rdata = r_dma_rdata;
  assign dma_ready = r_dma_ready;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign grant     = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed self-checking bench for mio_bus_arbiter (MEM_LAT = 2).
module tb_mio_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_ready, dma_ready, mem_en, mem_we, busy;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs cycles 1..4 of one transaction whose request is already presented
  // (edge 0 is the next rising edge). The winner drops req after the cycle
  // numbered drop_cyc has been checked (0 = never). Returns in cycle 4.
  task automatic do_txn(input string nm, input logic [1:0] g, input logic we,
                        input logic [31:0] a, input logic [31:0] wd, input int drop_cyc);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 2) begin
        chk({nm, "_en"},    64'(mem_en), 64'd1);
        chk({nm, "_we"},    64'(mem_we), 64'(we));
        chk({nm, "_addr"},  64'(mem_addr), 64'(a));
        chk({nm, "_wdata"}, 64'(mem_wdata), 64'(wd));
        chk({nm, "_gnt"},   64'(grant), 64'(g));
        chk({nm, "_rdy"},   64'({dma_ready, cpu_ready}), 64'd0);
        chk({nm, "_busy"},  64'(busy), 64'd1);
      end else if (k == 3) begin
        chk({nm, "_en3"},   64'({mem_en, mem_we}), 64'd0);
        chk({nm, "_rdy3"},  64'({dma_ready, cpu_ready}), 64'(g));
        chk({nm, "_gnt3"},  64'(grant), 64'(g));
        chk({nm, "_busy3"}, 64'(busy), 64'd1);
      end else begin
        chk({nm, "_rdy4"},  64'({dma_ready, cpu_ready}), 64'd0);
        chk({nm, "_gnt4"},  64'(grant), 64'd0);
        chk({nm, "_busy4"}, 64'(busy), 64'd0);
      end
      if (k == drop_cyc) begin
        if (g == 2'b01) cpu_req = 1'b0;
        else            dma_req = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;

    // 1. reset with random inputs: all outputs stay zero
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      dma_req = 1'($urandom); dma_we = 1'($urandom); dma_addr = $urandom; dma_wdata = $urandom;
      mem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("rst_data", 64'(|{cpu_rdata, dma_rdata, mem_addr, mem_wdata}), 64'd0);
      chk("rst_ctl",  64'({cpu_ready, dma_ready, mem_en, mem_we, grant, busy}), 64'd0);
    end
    cpu_req = 0; dma_req = 0; cpu_we = 0; dma_we = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_ctl", 64'({cpu_ready, dma_ready, mem_en, grant, busy}), 64'd0);
    end

    // 2. C read 0x10
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = 32'h0; mem_rdata = 32'hDEADBEEF;
    do_txn("crd", 2'b01, 1'b0, 32'h10, 32'h0, 3);
    chk("crd_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    chk("crd_drdata", 64'(dma_rdata), 64'h0);

    // 3. D write 0x40 / 0x12345678; read data on bus must not be captured
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h12345678; mem_rdata = 32'hCAFEF00D;
    do_txn("dwr", 2'b10, 1'b1, 32'h40, 32'h12345678, 3);
    chk("dwr_crdata", 64'(cpu_rdata), 64'hDEADBEEF);
    chk("dwr_drdata", 64'(dma_rdata), 64'h0);

    // D read 0x44
    dma_req = 1; dma_we = 0; dma_addr = 32'h44; dma_wdata = 32'h0; mem_rdata = 32'hA5A55A5A;
    do_txn("drd", 2'b10, 1'b0, 32'h44, 32'h0, 3);
    chk("drd_drdata", 64'(dma_rdata), 64'hA5A55A5A);
    chk("drd_crdata", 64'(cpu_rdata), 64'hDEADBEEF);

    // 4. both requesting continuously (last grant was D)
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; cpu_wdata = 32'h0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200; dma_wdata = 32'h0; mem_rdata = 32'h11112222;
`ifdef ARB_ROUND_ROBIN_EN
    do_txn("rr0", 2'b01, 1'b0, 32'h100, 32'h0, 0);
    do_txn("rr1", 2'b10, 1'b0, 32'h200, 32'h0, 0);
    do_txn("rr2", 2'b01, 1'b0, 32'h100, 32'h0, 0);
    do_txn("rr3", 2'b10, 1'b0, 32'h200, 32'h0, 0);
    chk("rr_drdata", 64'(dma_rdata), 64'h11112222);
`else
    do_txn("fp0", 2'b01, 1'b0, 32'h100, 32'h0, 0);
    do_txn("fp1", 2'b01, 1'b0, 32'h100, 32'h0, 0);
    do_txn("fp2", 2'b01, 1'b0, 32'h100, 32'h0, 0);
    chk("fp_drdata", 64'(dma_rdata), 64'hA5A55A5A);
`endif
    chk("both_crdata", 64'(cpu_rdata), 64'h11112222);
    cpu_req = 0; dma_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("both_idle", 64'({grant, busy}), 64'd0);

    // 5. reset during the second ACCESS cycle
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h60; cpu_wdata = 32'h77; mem_rdata = 32'h0;
    @(posedge clk);              // edge 0
    @(negedge clk);
    chk("ab_en1", 64'(mem_en), 64'd1);
    @(posedge clk);              // edge 1, second ACCESS cycle begins
    #2 reset = 1'b0;
    #1;
    chk("ab_en_drop", 64'({mem_en, mem_we}), 64'd0);
    chk("ab_busy", 64'({busy, grant}), 64'd0);
    cpu_req = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ab_quiet", 64'({cpu_ready, dma_ready, mem_en, grant, busy}), 64'd0);
    end
    chk("ab_crdata", 64'(cpu_rdata), 64'd0);

    // 6. C write, req dropped after first ACCESS cycle
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h55;
    do_txn("drop", 2'b01, 1'b1, 32'h80, 32'h55, 1);
    @(posedge clk);
    @(negedge clk);
    chk("drop_after", 64'({cpu_ready, mem_en, busy}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
